// File: rtl/sii_l2t_pkg.sv
// rtl/sii_l2t_pkg.sv - shared types and widths for the SII-to-L2T request scheduler
package sii_l2t_pkg;

  localparam int NUM_BANKS = 8;
  localparam int BANK_W    = $clog2(NUM_BANKS);
  localparam int HDR_W     = 32;
  localparam int CRED_W    = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VLD,
    ST_HDR0,
    ST_HDR1,
    ST_GAP
  } sched_state_e;

endpackage

// File: rtl/sii_l2t_credit_ctr.sv
// rtl/sii_l2t_credit_ctr.sv - one per-bank credit counter with saturation and sticky overflow flag
module sii_l2t_credit_ctr
  import sii_l2t_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              iol2clk,
  input  logic              rst_l,
  input  logic              i_dec,
  input  logic              i_inc,
  output logic [CRED_W-1:0] o_cnt,
  output logic              o_err
);

  localparam logic [CRED_W-1:0] FULL = CRED_W'(DEPTH);

  logic [CRED_W-1:0] r_cnt;
  logic              r_err;

  // A take and a return in the same cycle cancel; a lone return at full depth is a protocol error.
  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      r_cnt <= FULL;
      r_err <= 1'b0;
    end else if (i_inc && !i_dec) begin
      if (r_cnt == FULL) r_err <= 1'b1;
      else               r_cnt <= r_cnt + CRED_W'(1);
    end else if (i_dec && !i_inc) begin
      r_cnt <= r_cnt - CRED_W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_err = r_err;

endmodule

// File: rtl/sii_l2t_req_sched.sv
// rtl/sii_l2t_req_sched.sv - two-port round-robin request scheduler onto eight credit-controlled L2T banks
module sii_l2t_req_sched
  import sii_l2t_pkg::*;
#(
  parameter int IQ_DEPTH  = 16,
  parameter int WIB_DEPTH = 4
) (
  input  logic        iol2clk,
  input  logic        rst_l,
  input  logic        p0_req_vld,
  input  logic [2:0]  p0_req_bank,
  input  logic        p0_req_wri,
  input  logic [63:0] p0_req_hdr,
  output logic        p0_req_gnt,
  input  logic        p1_req_vld,
  input  logic [2:0]  p1_req_bank,
  input  logic        p1_req_wri,
  input  logic [63:0] p1_req_hdr,
  output logic        p1_req_gnt,
  output logic        sii_l2t0_req_vld,
  output logic [31:0] sii_l2t0_req,
  output logic        sii_l2t1_req_vld,
  output logic [31:0] sii_l2t1_req,
  output logic        sii_l2t2_req_vld,
  output logic [31:0] sii_l2t2_req,
  output logic        sii_l2t3_req_vld,
  output logic [31:0] sii_l2t3_req,
  output logic        sii_l2t4_req_vld,
  output logic [31:0] sii_l2t4_req,
  output logic        sii_l2t5_req_vld,
  output logic [31:0] sii_l2t5_req,
  output logic        sii_l2t6_req_vld,
  output logic [31:0] sii_l2t6_req,
  output logic        sii_l2t7_req_vld,
  output logic [31:0] sii_l2t7_req,
  input  logic        l2t0_sii_iq_dequeue,
  input  logic        l2t1_sii_iq_dequeue,
  input  logic        l2t2_sii_iq_dequeue,
  input  logic        l2t3_sii_iq_dequeue,
  input  logic        l2t4_sii_iq_dequeue,
  input  logic        l2t5_sii_iq_dequeue,
  input  logic        l2t6_sii_iq_dequeue,
  input  logic        l2t7_sii_iq_dequeue,
  input  logic        l2t0_sii_wib_dequeue,
  input  logic        l2t1_sii_wib_dequeue,
  input  logic        l2t2_sii_wib_dequeue,
  input  logic        l2t3_sii_wib_dequeue,
  input  logic        l2t4_sii_wib_dequeue,
  input  logic        l2t5_sii_wib_dequeue,
  input  logic        l2t6_sii_wib_dequeue,
  input  logic        l2t7_sii_wib_dequeue,
  output logic        credit_err,
  output logic        busy
);

  logic [NUM_BANKS-1:0] w_iq_ret, w_wib_ret, w_iq_take, w_wib_take, w_iq_err, w_wib_err;
  logic [CRED_W-1:0]    w_iq_cnt  [NUM_BANKS];
  logic [CRED_W-1:0]    w_wib_cnt [NUM_BANKS];

  sched_state_e         r_state, w_state_nxt;
  logic                 r_rr_ptr, r_gnt0, r_gnt1, r_busy;
  logic [BANK_W-1:0]    r_bank;
  logic [2*HDR_W-1:0]   r_hdr;
  logic [NUM_BANKS-1:0] r_bus_vld;
  logic [NUM_BANKS-1:0][HDR_W-1:0] r_bus_req;

  logic                 w_elig0, w_elig1, w_gnt0, w_gnt1, w_take, w_gnt_wri;
  logic [BANK_W-1:0]    w_gnt_bank;
  logic [HDR_W-1:0]     w_word;

  assign w_iq_ret  = {l2t7_sii_iq_dequeue, l2t6_sii_iq_dequeue, l2t5_sii_iq_dequeue, l2t4_sii_iq_dequeue,
                      l2t3_sii_iq_dequeue, l2t2_sii_iq_dequeue, l2t1_sii_iq_dequeue, l2t0_sii_iq_dequeue};
  assign w_wib_ret = {l2t7_sii_wib_dequeue, l2t6_sii_wib_dequeue, l2t5_sii_wib_dequeue, l2t4_sii_wib_dequeue,
                      l2t3_sii_wib_dequeue, l2t2_sii_wib_dequeue, l2t1_sii_wib_dequeue, l2t0_sii_wib_dequeue};

  assign w_elig0 = p0_req_vld && (w_iq_cnt[p0_req_bank] != '0) &&
                   (!p0_req_wri || (w_wib_cnt[p0_req_bank] != '0));
  assign w_elig1 = p1_req_vld && (w_iq_cnt[p1_req_bank] != '0) &&
                   (!p1_req_wri || (w_wib_cnt[p1_req_bank] != '0));

  // r_rr_ptr names the port that wins a tie; it flips to the other port after every grant.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_elig0 && (!w_elig1 || !r_rr_ptr)) w_gnt0 = 1'b1;
        else if (w_elig1)                       w_gnt1 = 1'b1;
        if (w_elig0 || w_elig1) w_state_nxt = ST_VLD;
      end
      ST_VLD:  w_state_nxt = ST_HDR0;
      ST_HDR0: w_state_nxt = ST_HDR1;
      ST_HDR1: w_state_nxt = ST_GAP;
      ST_GAP:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_take     = w_gnt0 || w_gnt1;
  assign w_gnt_bank = w_gnt1 ? p1_req_bank : p0_req_bank;
  assign w_gnt_wri  = w_gnt1 ? p1_req_wri  : p0_req_wri;

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    assign w_iq_take[g]  = w_take && (w_gnt_bank == BANK_W'(g));
    assign w_wib_take[g] = w_iq_take[g] && w_gnt_wri;

    sii_l2t_credit_ctr #(.DEPTH(IQ_DEPTH)) u_iq_ctr (
      .iol2clk (iol2clk),
      .rst_l   (rst_l),
      .i_dec   (w_iq_take[g]),
      .i_inc   (w_iq_ret[g]),
      .o_cnt   (w_iq_cnt[g]),
      .o_err   (w_iq_err[g])
    );

    sii_l2t_credit_ctr #(.DEPTH(WIB_DEPTH)) u_wib_ctr (
      .iol2clk (iol2clk),
      .rst_l   (rst_l),
      .i_dec   (w_wib_take[g]),
      .i_inc   (w_wib_ret[g]),
      .o_cnt   (w_wib_cnt[g]),
      .o_err   (w_wib_err[g])
    );
  end

  always_comb begin
    w_word = '0;
    if (r_state == ST_HDR0)      w_word = r_hdr[2*HDR_W-1:HDR_W];
    else if (r_state == ST_HDR1) w_word = r_hdr[HDR_W-1:0];
  end

  // Bus registers trail the FSM by one cycle so every bank output comes straight from a flop.
  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state   <= ST_IDLE;
      r_rr_ptr  <= 1'b0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_busy    <= 1'b0;
      r_bank    <= '0;
      r_hdr     <= '0;
      r_bus_vld <= '0;
      r_bus_req <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt0  <= w_gnt0;
      r_gnt1  <= w_gnt1;
      r_busy  <= (w_state_nxt != ST_IDLE);
      if (w_gnt0)      r_rr_ptr <= 1'b1;
      else if (w_gnt1) r_rr_ptr <= 1'b0;
      if (w_take) begin
        r_bank <= w_gnt_bank;
        r_hdr  <= w_gnt1 ? p1_req_hdr : p0_req_hdr;
      end
      for (int k = 0; k < NUM_BANKS; k++) begin
        r_bus_vld[k] <= (r_state == ST_VLD) && (r_bank == BANK_W'(k));
        r_bus_req[k] <= (r_bank == BANK_W'(k)) ? w_word : '0;
      end
    end
  end

  assign p0_req_gnt = r_gnt0;
  assign p1_req_gnt = r_gnt1;
  assign busy       = r_busy;
  assign credit_err = |{w_iq_err, w_wib_err};

  assign sii_l2t0_req_vld = r_bus_vld[0];
  assign sii_l2t1_req_vld = r_bus_vld[1];
  assign sii_l2t2_req_vld = r_bus_vld[2];
  assign sii_l2t3_req_vld = r_bus_vld[3];
  assign sii_l2t4_req_vld = r_bus_vld[4];
  assign sii_l2t5_req_vld = r_bus_vld[5];
  assign sii_l2t6_req_vld = r_bus_vld[6];
  assign sii_l2t7_req_vld = r_bus_vld[7];
  assign sii_l2t0_req     = r_bus_req[0];
  assign sii_l2t1_req     = r_bus_req[1];
  assign sii_l2t2_req     = r_bus_req[2];
  assign sii_l2t3_req     = r_bus_req[3];
  assign sii_l2t4_req     = r_bus_req[4];
  assign sii_l2t5_req     = r_bus_req[5];
  assign sii_l2t6_req     = r_bus_req[6];
  assign sii_l2t7_req     = r_bus_req[7];

endmodule

// File: tb/tb_sii_l2t_req_sched.sv
// tb/tb_sii_l2t_req_sched.sv - scoreboard bench for the SII-to-L2T request scheduler
module tb_sii_l2t_req_sched;

  localparam int IQD  = 16;
  localparam int WIBD = 4;

  logic        iol2clk = 1'b0;
  logic        rst_l   = 1'b0;
  logic        p0_req_vld = 1'b0, p0_req_wri = 1'b0, p1_req_vld = 1'b0, p1_req_wri = 1'b0;
  logic [2:0]  p0_req_bank = '0, p1_req_bank = '0;
  logic [63:0] p0_req_hdr = '0, p1_req_hdr = '0;
  logic        p0_req_gnt, p1_req_gnt, credit_err, busy;
  logic [7:0]  iq_deq = '0, wib_deq = '0;
  logic [7:0]  bus_vld;
  logic [31:0] bus_req [8];

  sii_l2t_req_sched #(.IQ_DEPTH(IQD), .WIB_DEPTH(WIBD)) dut (
    .iol2clk(iol2clk), .rst_l(rst_l),
    .p0_req_vld(p0_req_vld), .p0_req_bank(p0_req_bank), .p0_req_wri(p0_req_wri),
    .p0_req_hdr(p0_req_hdr), .p0_req_gnt(p0_req_gnt),
    .p1_req_vld(p1_req_vld), .p1_req_bank(p1_req_bank), .p1_req_wri(p1_req_wri),
    .p1_req_hdr(p1_req_hdr), .p1_req_gnt(p1_req_gnt),
    .sii_l2t0_req_vld(bus_vld[0]), .sii_l2t0_req(bus_req[0]),
    .sii_l2t1_req_vld(bus_vld[1]), .sii_l2t1_req(bus_req[1]),
    .sii_l2t2_req_vld(bus_vld[2]), .sii_l2t2_req(bus_req[2]),
    .sii_l2t3_req_vld(bus_vld[3]), .sii_l2t3_req(bus_req[3]),
    .sii_l2t4_req_vld(bus_vld[4]), .sii_l2t4_req(bus_req[4]),
    .sii_l2t5_req_vld(bus_vld[5]), .sii_l2t5_req(bus_req[5]),
    .sii_l2t6_req_vld(bus_vld[6]), .sii_l2t6_req(bus_req[6]),
    .sii_l2t7_req_vld(bus_vld[7]), .sii_l2t7_req(bus_req[7]),
    .l2t0_sii_iq_dequeue(iq_deq[0]), .l2t1_sii_iq_dequeue(iq_deq[1]),
    .l2t2_sii_iq_dequeue(iq_deq[2]), .l2t3_sii_iq_dequeue(iq_deq[3]),
    .l2t4_sii_iq_dequeue(iq_deq[4]), .l2t5_sii_iq_dequeue(iq_deq[5]),
    .l2t6_sii_iq_dequeue(iq_deq[6]), .l2t7_sii_iq_dequeue(iq_deq[7]),
    .l2t0_sii_wib_dequeue(wib_deq[0]), .l2t1_sii_wib_dequeue(wib_deq[1]),
    .l2t2_sii_wib_dequeue(wib_deq[2]), .l2t3_sii_wib_dequeue(wib_deq[3]),
    .l2t4_sii_wib_dequeue(wib_deq[4]), .l2t5_sii_wib_dequeue(wib_deq[5]),
    .l2t6_sii_wib_dequeue(wib_deq[6]), .l2t7_sii_wib_dequeue(wib_deq[7]),
    .credit_err(credit_err), .busy(busy)
  );

  always #5 iol2clk = ~iol2clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: credit pools, a busy countdown and last-granted port, evaluated per clock.
  typedef struct {int port; logic [2:0] bank; logic [63:0] hdr;} pkt_t;
  pkt_t exp_q[$];
  pkt_t cur;
  int   m_iq[8], m_wib[8];
  int   m_busy, m_last, g;
  bit   m_err, e0, e1;
  logic [2:0] gbank;
  bit   gwri;
  int   ph = 5;

  function automatic bit elig(input bit v, input logic [2:0] b, input bit w);
    return v && (m_iq[b] > 0) && (!w || (m_wib[b] > 0));
  endfunction

  always @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int k = 0; k < 8; k++) begin m_iq[k] = IQD; m_wib[k] = WIBD; end
      m_busy = 0; m_last = 1; m_err = 0;
      exp_q.delete();
    end else begin
      e0 = elig(p0_req_vld, p0_req_bank, p0_req_wri);
      e1 = elig(p1_req_vld, p1_req_bank, p1_req_wri);
      g  = -1;
      if (m_busy > 0) m_busy--;
      else if (e0 || e1) begin
        g = (e0 && e1) ? 1 - m_last : (e0 ? 0 : 1);
        gbank = (g == 1) ? p1_req_bank : p0_req_bank;
        gwri  = (g == 1) ? p1_req_wri  : p0_req_wri;
        exp_q.push_back('{g, gbank, (g == 1) ? p1_req_hdr : p0_req_hdr});
        m_busy = 4;
        m_last = g;
      end
      for (int k = 0; k < 8; k++) begin
        m_iq[k]  += int'(iq_deq[k])  - int'(g >= 0 && gbank == 3'(k));
        m_wib[k] += int'(wib_deq[k]) - int'(g >= 0 && gbank == 3'(k) && gwri);
        if (m_iq[k] > IQD)   begin m_iq[k]  = IQD;  m_err = 1; end
        if (m_wib[k] > WIBD) begin m_wib[k] = WIBD; m_err = 1; end
      end
    end
  end

  // Monitor: every cycle pop the model's grant (if any) and check grant, bus and status outputs.
  always @(negedge iol2clk) begin
    logic [1:0]  eg;
    logic [7:0]  ev;
    logic [31:0] er;
    if (!rst_l) begin
      ph = 5;
      chk("rst_bus_vld", bus_vld, 0);
      chk("rst_gnt", {p1_req_gnt, p0_req_gnt}, 0);
      chk("rst_busy", busy, 0);
    end else begin
      eg = 2'b00;
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        eg  = (cur.port == 1) ? 2'b10 : 2'b01;
        ph  = 0;
      end else if (ph < 5) ph++;
      chk("gnt", {p1_req_gnt, p0_req_gnt}, eg);
      ev = '0;
      if (ph == 1) ev[cur.bank] = 1'b1;
      chk("bus_vld", bus_vld, ev);
      for (int k = 0; k < 8; k++) begin
        er = '0;
        if (cur.bank == 3'(k) && ph == 2) er = cur.hdr[63:32];
        if (cur.bank == 3'(k) && ph == 3) er = cur.hdr[31:0];
        chk($sformatf("bus_req%0d", k), bus_req[k], er);
      end
      chk("busy", busy, m_busy > 0);
      chk("credit_err", credit_err, m_err);
    end
  end

  task automatic idle_ports();
    p0_req_vld = 0; p1_req_vld = 0; iq_deq = '0; wib_deq = '0;
  endtask

  task automatic do_reset();
    @(negedge iol2clk);
    #1 rst_l = 0;
    idle_ports();
    repeat (2) @(negedge iol2clk);
    rst_l = 1;
  endtask

  task automatic set_req(input int port, input logic [2:0] bank, input logic wri, input logic [63:0] hdr);
    if (port == 0) begin p0_req_vld = 1; p0_req_bank = bank; p0_req_wri = wri; p0_req_hdr = hdr; end
    else           begin p1_req_vld = 1; p1_req_bank = bank; p1_req_wri = wri; p1_req_hdr = hdr; end
  endtask

  task automatic wait_gnt(input int port, input int max, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge iol2clk);
      if ((port == 0 && p0_req_gnt) || (port == 1 && p1_req_gnt)) begin
        cyc = i;
        if (port == 0) p0_req_vld = 0; else p1_req_vld = 0;
        break;
      end
    end
  endtask

  task automatic send(input int port, input logic [2:0] bank, input logic wri);
    int c;
    set_req(port, bank, wri, {$urandom, $urandom});
    wait_gnt(port, 40, c);
    chk("send_granted", c > 0, 1);
  endtask

  initial begin
    int c, n, quiet;
    int gp[$], gc[$];
    logic [31:0] orv;

    do_reset();
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_err", credit_err, 0);
    chk("reset_bus", bus_vld, 0);

    // Single read to bank 3 straight after reset release.
    set_req(0, 3'd3, 0, 64'hAAAA_0001_BBBB_0002);
    wait_gnt(0, 10, c);
    chk("req036_gnt_latency", c, 1);
    @(negedge iol2clk); chk("req036_vld", bus_vld, 8'h08);
    @(negedge iol2clk); chk("req036_hdr0", bus_req[3], 32'hAAAA0001);
    @(negedge iol2clk); chk("req036_hdr1", bus_req[3], 32'hBBBB0002);
    @(negedge iol2clk); chk("req036_gap", bus_req[3], 0);

    // Both ports always valid: alternate, five cycles apart, p1 first since p0 went last.
    set_req(0, 3'd1, 0, {$urandom, $urandom});
    set_req(1, 3'd2, 0, {$urandom, $urandom});
    for (int i = 0; i < 60 && gp.size() < 6; i++) begin
      @(negedge iol2clk);
      if (p0_req_gnt) begin gp.push_back(0); gc.push_back(i); p0_req_hdr = {$urandom, $urandom}; end
      if (p1_req_gnt) begin gp.push_back(1); gc.push_back(i); p1_req_hdr = {$urandom, $urandom}; end
    end
    idle_ports();
    chk("req037_ngrants", gp.size(), 6);
    if (gp.size() > 0) chk("req037_first", gp[0], 1);
    for (int i = 1; i < gp.size(); i++) begin
      chk("req037_alt", gp[i], 1 - gp[i-1]);
      chk("req037_gap", gc[i] - gc[i-1], 5);
    end
    repeat (6) @(negedge iol2clk);

    // IQ exhaustion on bank 5.
    do_reset();
    for (int i = 0; i < 16; i++) send(0, 3'd5, 0);
    set_req(0, 3'd5, 0, {$urandom, $urandom});
    wait_gnt(0, 20, c);
    chk("req038_17th_blocked", c, -1);
    iq_deq[5] = 1;
    @(negedge iol2clk);
    iq_deq[5] = 0;
    chk("req038_no_early_gnt", p0_req_gnt, 0);
    @(negedge iol2clk);
    chk("req038_gnt_after_deq", p0_req_gnt, 1);
    p0_req_vld = 0;
    repeat (6) @(negedge iol2clk);

    // WIB exhaustion on bank 0 must not block a read from the other port.
    do_reset();
    for (int i = 0; i < 4; i++) send(0, 3'd0, 1);
    set_req(0, 3'd0, 1, {$urandom, $urandom});
    set_req(1, 3'd0, 0, {$urandom, $urandom});
    wait_gnt(1, 20, c);
    chk("req039_p1_read_gnt", c > 0, 1);
    wait_gnt(0, 10, c);
    chk("req039_p0_wri_blocked", c, -1);
    wib_deq[0] = 1;
    @(negedge iol2clk);
    wib_deq[0] = 0;
    wait_gnt(0, 5, c);
    chk("req039_p0_after_wib_deq", c, 1);
    repeat (6) @(negedge iol2clk);

    // Overflow at full depth, then grant and dequeue in the same cycle.
    do_reset();
    iq_deq[6] = 1;
    @(negedge iol2clk);
    iq_deq[6] = 0;
    chk("req040_err_set", credit_err, 1);
    repeat (5) @(negedge iol2clk);
    chk("req040_err_sticky", credit_err, 1);
    set_req(0, 3'd6, 0, {$urandom, $urandom});
    iq_deq[6] = 1;
    n = 0; quiet = 0;
    for (int i = 0; i < 200 && quiet < 15; i++) begin
      @(negedge iol2clk);
      iq_deq[6] = 0;
      if (p0_req_gnt) begin n++; quiet = 0; p0_req_hdr = {$urandom, $urandom}; end
      else quiet++;
    end
    p0_req_vld = 0;
    chk("req040_grants_before_block", n, 17);
    chk("req040_err_still", credit_err, 1);

    // Reset in the middle of a packet.
    do_reset();
    set_req(0, 3'd4, 0, 64'h1234_5678_9ABC_DEF0);
    wait_gnt(0, 5, c);
    chk("req041_gnt", c, 1);
    @(negedge iol2clk);
    chk("req041_vld_before", bus_vld, 8'h10);
    #1 rst_l = 0;
    #1;
    orv = '0;
    for (int k = 0; k < 8; k++) orv |= bus_req[k];
    chk("req041_vld_async_zero", bus_vld, 0);
    chk("req041_req_async_zero", orv, 0);
    chk("req041_busy_async_zero", busy, 0);
    repeat (2) @(negedge iol2clk);
    rst_l = 1;
    repeat (8) @(negedge iol2clk);
    orv = '0;
    for (int k = 0; k < 8; k++) orv |= bus_req[k];
    chk("req041_no_resume", orv, 0);
    for (int i = 0; i < 4; i++) send(0, 3'd7, 1);
    set_req(0, 3'd7, 1, {$urandom, $urandom});
    wait_gnt(0, 15, c);
    chk("req041_wib_full_after_reset", c, -1);
    idle_ports();
    repeat (6) @(negedge iol2clk);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge iol2clk);
      if (p0_req_vld && p0_req_gnt) p0_req_vld = 0;
      if (p1_req_vld && p1_req_gnt) p1_req_vld = 0;
      if (!p0_req_vld && $urandom_range(0, 2) == 0)
        set_req(0, 3'($urandom_range(0, 3)), $urandom_range(0, 2) == 0, {$urandom, $urandom});
      if (!p1_req_vld && $urandom_range(0, 2) == 0)
        set_req(1, 3'($urandom_range(0, 3)), $urandom_range(0, 2) == 0, {$urandom, $urandom});
      for (int k = 0; k < 8; k++) begin
        iq_deq[k]  = (m_iq[k] < IQD)   && ($urandom_range(0, 29) == 0);
        wib_deq[k] = (m_wib[k] < WIBD) && ($urandom_range(0, 79) == 0);
      end
    end
    idle_ports();
    repeat (10) @(negedge iol2clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
